// File: rtl/ms_access_ctl_pkg.sv
// Shared main-store package: default store geometry, access FSM encoding and
// a helper for sizing the per-word bit counter.
package ms_access_ctl_pkg;

  localparam int unsigned MS_WORD_LENGTH = 20;
  localparam int unsigned MS_ADDR_BITS   = 5;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_SETUP  = 3'd1;
  localparam logic [ST_W-1:0] ST_BIT_LO = 3'd2;
  localparam logic [ST_W-1:0] ST_BIT_HI = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE   = 3'd4;

  // A one-bit word still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ms_bit_shifter.sv
// LSB-first word shift register shared by write serialisation and read capture;
// the serial input enters at the MSB so a full word of shifts lands bit 0 at bit 0.
module ms_bit_shifter
  import ms_access_ctl_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = MS_WORD_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [WORD_LENGTH-1:0] load_word,
  input  logic                   shift,
  input  logic                   serial_in,
  output logic [WORD_LENGTH-1:0] word_next_c
);

  logic [WORD_LENGTH-1:0] word;

  always_comb begin
    word_next_c = word;
    if (load) begin
      word_next_c = load_word;
    end else if (shift) begin
      word_next_c = (word >> 1) | (WORD_LENGTH'(serial_in) << (WORD_LENGTH - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else begin
      word <= word_next_c;
    end
  end

endmodule

// File: rtl/ms_access_ctl.sv
// Main-store access controller: serialises one word per request to/from the
// bit-serial store, two clocks (digit low/high) per bit, LSB first.
module ms_access_ctl
  import ms_access_ctl_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = MS_WORD_LENGTH,
  parameter int unsigned ADDR_BITS   = MS_ADDR_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   we,
  input  logic [ADDR_BITS-1:0]   addr,
  input  logic [WORD_LENGTH-1:0] wdata,
  output logic                   ready,
  output logic                   done,
  output logic [WORD_LENGTH-1:0] rdata,
  output logic [ADDR_BITS-1:0]   ms_addr,
  output logic                   ms_xtb,
  output logic                   ms_dpg,
  output logic                   ms_zero,
  output logic                   ms_data_in,
  input  logic                   ms_data_out
);

  localparam int unsigned CNT_W = cnt_width(WORD_LENGTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LENGTH - 1);

  logic [ST_W-1:0]        state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic                   we_q;
  logic [ADDR_BITS-1:0]   addr_q;

  logic                   load, shift;
  logic [WORD_LENGTH-1:0] word_next_c;

  logic                   accept;
  logic                   cur_we;
  logic [ADDR_BITS-1:0]   cur_addr;
  logic                   active_next, bit_phase_next;
  logic                   ready_next, done_next, dpg_next, xtb_next;
  logic                   zero_next, data_in_next, rdata_load;
  logic [ADDR_BITS-1:0]   ms_addr_next;

  ms_bit_shifter #(
    .WORD_LENGTH (WORD_LENGTH)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_word   (wdata),
    .shift       (shift),
    .serial_in   (ms_data_out),
    .word_next_c (word_next_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, bit counter and shifter control.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_next = ST_SETUP;
          cnt_next   = '0;
          load       = 1'b1;
        end
      end
      ST_SETUP:  state_next = ST_BIT_LO;
      ST_BIT_LO: state_next = ST_BIT_HI;
      ST_BIT_HI: begin
        shift = 1'b1;
        if (cnt == LAST_BIT) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_BIT_LO;
          cnt_next   = cnt + CNT_W'(1);
        end
      end
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Store-side outputs are computed for the state being entered so they are
  // registered yet line up with that state; in IDLE the raw request is used.
  always_comb begin
    accept         = (state == ST_IDLE) && req;
    cur_we         = accept ? we : we_q;
    cur_addr       = accept ? addr : addr_q;
    active_next    = (state_next == ST_SETUP) || (state_next == ST_BIT_LO) ||
                     (state_next == ST_BIT_HI);
    bit_phase_next = (state_next == ST_BIT_LO) || (state_next == ST_BIT_HI);
    ready_next     = (state_next == ST_IDLE);
    done_next      = (state_next == ST_DONE);
    dpg_next       = (state_next == ST_BIT_HI);
    xtb_next       = active_next && cur_we;
    ms_addr_next   = active_next ? cur_addr : '0;
    data_in_next   = bit_phase_next && cur_we && word_next_c[0];
    zero_next      = bit_phase_next && cur_we && !word_next_c[0];
    rdata_load     = (state == ST_BIT_HI) && (state_next == ST_DONE) && !we_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      ready      <= 1'b1;
      done       <= 1'b0;
      rdata      <= '0;
      ms_addr    <= '0;
      ms_xtb     <= 1'b0;
      ms_dpg     <= 1'b0;
      ms_zero    <= 1'b0;
      ms_data_in <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      ready      <= ready_next;
      done       <= done_next;
      ms_addr    <= ms_addr_next;
      ms_xtb     <= xtb_next;
      ms_dpg     <= dpg_next;
      ms_zero    <= zero_next;
      ms_data_in <= data_in_next;
      if (accept) begin
        we_q   <= we;
        addr_q <= addr;
      end
      if (rdata_load) begin
        rdata <= word_next_c;
      end
    end
  end

endmodule

// File: doc/ms_access_ctl.md
MS_ACCESS_CTL -- requirements
Module: ms_access_ctl

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 20, bits per store word.
REQ-002 SHALL have parameter ADDR_BITS, default 5, store line address width (32 lines).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req  input  1  access request, sampled in IDLE only.
REQ-006 SHALL have port we  input  1  1 = write word, 0 = read word; captured with req.
REQ-007 SHALL have port addr  input  ADDR_BITS  line address; captured with req.
REQ-008 SHALL have port wdata  input  WORD_LENGTH  write word; captured with req.
REQ-009 SHALL have port ready  output  1  high only in IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when an access completes.
REQ-011 SHALL have port rdata  output  WORD_LENGTH  last word read; held until the next read completes.
REQ-012 SHALL have port ms_addr  output  ADDR_BITS  line address to main store.
REQ-013 SHALL have port ms_xtb  output  1  store write enable.
REQ-014 SHALL have port ms_dpg  output  1  digit pulse, one per bit.
REQ-015 SHALL have port ms_zero  output  1  write-zero strobe for the current bit.
REQ-016 SHALL have port ms_data_in  output  1  serial write bit.
REQ-017 SHALL have port ms_data_out  input  1  serial read bit from store.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, BIT_LO, BIT_HI, DONE.
REQ-019 IDLE with req=1 SHALL capture we/addr/wdata, clear bit counter, and go to SETUP; req=0 stays in IDLE.
REQ-020 SETUP SHALL last exactly one cycle, drive ms_addr, assert ms_xtb if write, then go to BIT_LO.
REQ-021 BIT_LO SHALL present bit[n] (LSB first) on ms_data_in and ~bit[n] on ms_zero for writes; both 0 for reads; ms_dpg=0.
REQ-022 BIT_HI SHALL hold BIT_LO data/zero values and assert ms_dpg=1 for exactly one cycle.
REQ-023 On reads, ms_data_out SHALL be captured at the clock edge ending BIT_HI into bit[n] of a shift register.
REQ-024 BIT_HI SHALL go to BIT_LO with n+1 if n<WORD_LENGTH-1, else to DONE.
REQ-025 DONE SHALL pulse done for one cycle, update rdata (reads only), drop ms_xtb, and return to IDLE.
REQ-026 Access latency SHALL be 2*WORD_LENGTH+2 cycles from the req-accepting edge to the done cycle inclusive (42 at default).
REQ-027 ms_addr and ms_xtb SHALL stay constant from SETUP through the last BIT_HI.
REQ-028 req asserted outside IDLE SHALL be ignored; input changes mid-access SHALL not affect the access in flight.
REQ-029 Bit counter SHALL be ceil(log2(WORD_LENGTH)) bits wide and SHALL never wrap past WORD_LENGTH-1.
REQ-030 A write SHALL leave rdata unchanged.

Reset
REQ-031 rst=1 SHALL force IDLE immediately, including mid-access; the partial access is abandoned with no done pulse.
REQ-032 During and after reset: ready=1, done=0, rdata=0, ms_addr=0, ms_xtb=0, ms_dpg=0, ms_zero=0, ms_data_in=0.

Structure
REQ-033 The FSM state encoding and the default WORD_LENGTH/ADDR_BITS constants SHALL live in the shared store package used by the main store.
REQ-034 SHALL contain one sub-module, ms_bit_shifter: a WORD_LENGTH-bit LSB-first shift register for both write serialisation and read capture.

Verification
REQ-035 Write addr=3, wdata=20'hA5A5A with the store model attached -> 20 ms_dpg pulses; ms_data_in sequence 0,1,0,1,1,...; ms_xtb high throughout; done at cycle 42.
REQ-036 Read addr=3 after REQ-035 -> rdata=20'hA5A5A at done; ms_xtb low throughout; ms_zero never high.
REQ-037 Write then read address 31 with wdata=20'hFFFFF, then 20'h00000 -> rdata matches each time; ms_zero pattern is the complement of ms_data_in.
REQ-038 rst pulsed at the 10th ms_dpg of a write -> all outputs at reset values in the same cycle; no done; next read returns previous contents of the stored line.
REQ-039 req held high continuously for 3 accesses -> each accepted only in IDLE; accesses back-to-back 43 cycles apart; mid-access addr changes have no effect.
